// File: rtl/alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// alu_op_sequencer
//
// Purpose:
//    Initiator-side companion to the combinational N-bit ALU. It accepts one
//    command at a time over a valid/ready interface. A command is either a
//    load-immediate or an ALU operation. For an ALU operation it reads the
//    operands from an internal register file and drives the ALU for one
//    cycle. It then captures the ALU result and carry, writes the result
//    back, and returns a response over a second valid/ready interface.
//
// Parameters:
//    N  - datapath width (matches the ALU's N)
//    AW - register-file address width (2**AW entries)
//
// Ports:
//    clk, rst       - clock and synchronous active-high reset
//    cmd_valid      - command present
//    cmd_ready      - sequencer can accept a command (IDLE only)
//    cmd_load       - 1 = load immediate, 0 = ALU operation
//    cmd_op         - ALU select code (ignored for loads)
//    cmd_dst        - destination register index
//    cmd_src_a/b    - operand register indices (A -> ALU R2, B -> ALU R3)
//    cmd_imm        - immediate value for loads
//    alu_a/alu_b    - operands driven to ALU R2/R3
//    alu_sel        - ALU select code
//    alu_r/alu_cout - ALU result R1 and carry out
//    rsp_valid      - response present
//    rsp_ready      - consumer accepts the response
//    rsp_data       - value written to rsp_dst
//    rsp_carry      - carry captured with the result (0 for loads)
//    rsp_dst        - destination index of the completed command
//    carry_flag     - sticky copy of the last ALU carry
// ---------------------------------------------------------------------------
module alu_op_sequencer #(
   parameter int N  = 32,
   parameter int AW = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic          cmd_load,
   input  logic [2:0]    cmd_op,
   input  logic [AW-1:0] cmd_dst,
   input  logic [AW-1:0] cmd_src_a,
   input  logic [AW-1:0] cmd_src_b,
   input  logic [N-1:0]  cmd_imm,
   output logic [N-1:0]  alu_a,
   output logic [N-1:0]  alu_b,
   output logic [2:0]    alu_sel,
   input  logic [N-1:0]  alu_r,
   input  logic          alu_cout,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [N-1:0]  rsp_data,
   output logic          rsp_carry,
   output logic [AW-1:0] rsp_dst,
   output logic          carry_flag
);

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      RESP
   } state_t;

   state_t        state;
   logic [N-1:0]  regfile [2**AW];
   logic [AW-1:0] dst_q;

   // Single sequential process for the FSM, the register file and every
   // output. cmd_ready and rsp_valid are registered copies of "state is
   // IDLE" and "state is RESP". They are updated together with each state
   // transition, so no combinational path runs from cmd_valid.
   // The register file is read only at acceptance in IDLE. By then any
   // earlier writeback has completed, so aliasing between src and dst
   // needs no forwarding.
   // alu_a/alu_b/alu_sel change only when an ALU op is accepted. The ALU
   // therefore sees stable operands throughout EXEC, and loads leave them
   // untouched.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cmd_ready  <= 1'b1;
         rsp_valid  <= 1'b0;
         rsp_data   <= '0;
         rsp_carry  <= 1'b0;
         rsp_dst    <= '0;
         carry_flag <= 1'b0;
         alu_a      <= '0;
         alu_b      <= '0;
         alu_sel    <= 3'b000;
         dst_q      <= '0;
         regfile    <= '{default: '0};
      end else begin
         unique case (state)
            IDLE: begin
               if (cmd_valid) begin
                  cmd_ready <= 1'b0;
                  if (cmd_load) begin
                     regfile[cmd_dst] <= cmd_imm;
                     rsp_data         <= cmd_imm;
                     rsp_carry        <= 1'b0;
                     rsp_dst          <= cmd_dst;
                     rsp_valid        <= 1'b1;
                     state            <= RESP;
                  end else begin
                     alu_a   <= regfile[cmd_src_a];
                     alu_b   <= regfile[cmd_src_b];
                     alu_sel <= cmd_op;
                     dst_q   <= cmd_dst;
                     state   <= EXEC;
                  end
               end
            end
            EXEC: begin
               regfile[dst_q] <= alu_r;
               rsp_data       <= alu_r;
               rsp_carry      <= alu_cout;
               carry_flag     <= alu_cout;
               rsp_dst        <= dst_q;
               rsp_valid      <= 1'b1;
               state          <= RESP;
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  cmd_ready <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               rsp_valid <= 1'b0;
               cmd_ready <= 1'b1;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule
